alu_cmd_queue: RTL and testbench

Upstream command stage for the 4-bit ALU. Captures operand/opcode commands from the pin interface on a synchronised strobe edge and buffers them in a small FIFO. Issues commands to the ALU over a valid/ready handshake. Flags overflow, illegal opcodes and divide-by-zero so the ALU never silently receives garbage.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/strobe_sync_edge.sv | 30 +++
 rtl/alu_cmd_queue.sv | 134 +++++++++++++
 tb/tb_alu_cmd_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, command record and opcode legality check
// for the 4-bit ALU command path.
package alu_pkg;

    localparam int CMD_OPW = 3;
    localparam int CMD_DW  = 4;

    localparam logic [CMD_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [CMD_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [CMD_OPW-1:0] OP_AND = 3'b010;
    localparam logic [CMD_OPW-1:0] OP_DIV = 3'b011;
    localparam logic [CMD_OPW-1:0] OP_OR  = 3'b100;
    localparam logic [CMD_OPW-1:0] OP_MUL = 3'b101;

    typedef struct packed {
        logic [CMD_OPW-1:0] op;
        logic [CMD_DW-1:0]  a;
        logic [CMD_DW-1:0]  b;
    } cmd_t;

    // Encodings 110 and 111 are unassigned and must never reach the ALU.
    function automatic logic is_legal_op(input logic [CMD_OPW-1:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin strobe plus a delay flop
// that turns each synchronised rising edge into a single-cycle pulse.
module strobe_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic stb_i,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;

    // Resetting to RST_VAL=1 means a strobe already high at reset release
    // looks like a level, not a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= stb_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue in front of the ALU: captures pin commands on a strobe edge,
// buffers them in a show-ahead FIFO and issues them over valid/ready.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = 3,
    parameter int DW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_stb_i,
    input  logic [OPW-1:0]           cmd_op_i,
    input  logic [DW-1:0]            cmd_a_i,
    input  logic [DW-1:0]            cmd_b_i,
    input  logic                     flush_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [OPW-1:0]           issue_op_o,
    output logic [DW-1:0]            issue_a_o,
    output logic [DW-1:0]            issue_b_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     illegal_o,
    output logic                     divzero_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          push_req;
    cmd_t          mem_q [DEPTH];
    cmd_t          head, wr_cmd;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, ill_q, ill_d, dz_q, dz_d;
    logic          valid, pop, push_legal, do_write;

    strobe_sync_edge #(
        .RST_VAL (1'b1)
    ) u_stb (
        .clk    (clk),
        .rst    (rst),
        .stb_i  (wr_stb_i),
        .edge_o (push_req)
    );

    assign wr_cmd = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
    assign head   = mem_q[rd_ptr_q];
    assign valid  = (count_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;
        dz_d       = dz_q;
        pop        = valid & issue_ready_i;
        push_legal = push_req & is_legal_op(cmd_op_i);
        // A full queue still accepts a push when the head leaves this cycle.
        do_write   = push_legal & ((count_q != FULL_CNT) | pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            ill_d    = 1'b0;
            dz_d     = 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push_req && !is_legal_op(cmd_op_i)) begin
                ill_d = 1'b1;
            end
            if (push_legal && !do_write) begin
                ovf_d = 1'b1;
            end
            if (pop && head.op == OP_DIV && head.b == '0) begin
                dz_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            dz_q     <= dz_d;
        end
    end

    // Storage carries no reset; stale entries are masked by the count.
    always_ff @(posedge clk) begin
        if (do_write && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_cmd;
        end
    end

    assign issue_valid_o = valid;
    assign issue_op_o    = valid ? head.op : '0;
    assign issue_a_o     = valid ? head.a  : '0;
    assign issue_b_o     = valid ? head.b  : '0;
    assign count_o       = count_q;
    assign full_o        = (count_q == FULL_CNT);
    assign empty_o       = ~valid;
    assign overflow_o    = ovf_q;
    assign illegal_o     = ill_q;
    assign divzero_o     = dz_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios with literal
// expectations plus a randomized phase against a queue-based reference model.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic [2:0] op  = '0;
    logic [3:0] a   = '0;
    logic [3:0] b   = '0;
    logic       flush = 1'b0;
    logic       rdy   = 1'b0;

    logic       vld_o;
    logic [2:0] op_o;
    logic [3:0] a_o, b_o;
    logic [2:0] cnt_o;
    logic       full_o, empty_o, ovf_o, ill_o, dz_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_cmd_queue #(.DEPTH(DEPTH), .OPW(3), .DW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_stb_i      (stb),
        .cmd_op_i      (op),
        .cmd_a_i       (a),
        .cmd_b_i       (b),
        .flush_i       (flush),
        .issue_valid_o (vld_o),
        .issue_ready_i (rdy),
        .issue_op_o    (op_o),
        .issue_a_o     (a_o),
        .issue_b_o     (b_o),
        .count_o       (cnt_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (ovf_o),
        .illegal_o     (ill_o),
        .divzero_o     (dz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: queue of {op,a,b}; a push is taken two edges after
    // the edge at which the strobe is first seen high following a low sample.
    logic [10:0] mq[$];
    bit m_ovf = 0, m_ill = 0, m_dz = 0;
    bit h0 = 1, h1 = 1, h2 = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_ill = 0; m_dz = 0;
            h0 = 1; h1 = 1; h2 = 1;
        end else begin
            bit push_now, pop_now;
            logic [10:0] hd;
            push_now = h1 && !h2;
            pop_now  = (mq.size() > 0) && rdy;
            if (flush) begin
                mq.delete();
                m_ovf = 0; m_ill = 0; m_dz = 0;
            end else begin
                if (pop_now) begin
                    hd = mq.pop_front();
                    if (hd[10:8] == 3'd3 && hd[3:0] == 4'd0) m_dz = 1;
                end
                if (push_now) begin
                    if (op >= 3'd6)               m_ill = 1;
                    else if (mq.size() < DEPTH)   mq.push_back({op, a, b});
                    else                          m_ovf = 1;
                end
            end
            h2 = h1; h1 = h0; h0 = stb;
        end
    end

    always @(negedge clk) begin
        logic [10:0] hd;
        hd = (mq.size() > 0) ? mq[0] : 11'd0;
        chk("count", int'(cnt_o), mq.size());
        chk("valid", int'(vld_o), int'(mq.size() > 0));
        chk("full",  int'(full_o), int'(mq.size() == DEPTH));
        chk("empty", int'(empty_o), int'(mq.size() == 0));
        chk("overflow", int'(ovf_o), int'(m_ovf));
        chk("illegal",  int'(ill_o), int'(m_ill));
        chk("divzero",  int'(dz_o),  int'(m_dz));
        chk("head", int'({op_o, a_o, b_o}), int'(hd));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe high for three sampled edges (push lands on the third), then low.
    task automatic pulse(input logic [2:0] o, input logic [3:0] va, input logic [3:0] vb,
                         input bit pop_at_push);
        op = o; a = va; b = vb; stb = 1'b1;
        step(); step();
        if (pop_at_push) rdy = 1'b1;
        step();
        rdy = 1'b0; stb = 1'b0;
        step(); step();
    endtask

    task automatic drain(input int n);
        rdy = 1'b1;
        repeat (n) step();
        rdy = 1'b0;
    endtask

    initial begin
        // Reset with strobe held high: release must not produce a push.
        stb = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (4) step();
        chk("lit_rst_count", int'(cnt_o), 0);
        chk("lit_rst_empty", int'(empty_o), 1);
        chk("lit_rst_valid", int'(vld_o), 0);
        stb = 1'b0;
        repeat (3) step();

        // Single command, held at the head until accepted.
        pulse(3'b000, 4'h3, 4'h5, 0);
        chk("lit_one_count", int'(cnt_o), 1);
        chk("lit_one_valid", int'(vld_o), 1);
        chk("lit_one_head", int'({op_o, a_o, b_o}), int'({3'b000, 4'h3, 4'h5}));
        repeat (4) step();
        chk("lit_one_hold", int'({op_o, a_o, b_o}), int'({3'b000, 4'h3, 4'h5}));
        drain(1);
        chk("lit_one_popped", int'(cnt_o), 0);

        // Five pushes into four slots.
        pulse(3'b000, 4'h1, 4'h2, 0);
        pulse(3'b001, 4'h3, 4'h4, 0);
        pulse(3'b010, 4'h5, 4'h6, 0);
        pulse(3'b100, 4'h7, 4'h8, 0);
        pulse(3'b101, 4'h9, 4'hA, 0);
        chk("lit_ovf_count", int'(cnt_o), 4);
        chk("lit_ovf_full", int'(full_o), 1);
        chk("lit_ovf_flag", int'(ovf_o), 1);
        chk("lit_ovf_head_a", int'(a_o), 1);
        drain(4);
        chk("lit_drain_count", int'(cnt_o), 0);

        // Full queue with a pop in the push cycle.
        flush = 1'b1; step(); flush = 1'b0;
        pulse(3'b000, 4'h1, 4'h1, 0);
        pulse(3'b001, 4'h2, 4'h2, 0);
        pulse(3'b010, 4'h3, 4'h3, 0);
        pulse(3'b100, 4'h4, 4'h4, 0);
        pulse(3'b101, 4'h5, 4'h5, 1);
        chk("lit_pp_count", int'(cnt_o), 4);
        chk("lit_pp_ovf", int'(ovf_o), 0);
        chk("lit_pp_head_a", int'(a_o), 2);
        drain(4);

        // Illegal opcode, divide by zero, then flush.
        pulse(3'b110, 4'h1, 4'h1, 0);
        chk("lit_ill_flag", int'(ill_o), 1);
        chk("lit_ill_count", int'(cnt_o), 0);
        pulse(3'b011, 4'h4, 4'h0, 0);
        chk("lit_dz_before", int'(dz_o), 0);
        drain(1);
        chk("lit_dz_after", int'(dz_o), 1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("lit_flush_flags", int'({ovf_o, ill_o, dz_o}), 0);
        chk("lit_flush_count", int'(cnt_o), 0);

        // Asynchronous reset while a pop is pending.
        pulse(3'b001, 4'h6, 4'h7, 0);
        pulse(3'b010, 4'h8, 4'h9, 0);
        chk("lit_pre_rst_count", int'(cnt_o), 2);
        rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_valid", int'(vld_o), 0);
        chk("lit_arst_count", int'(cnt_o), 0);
        step();
        rst = 1'b0; rdy = 1'b0;
        step();

        // Pointer wrap: six commands through the queue with an eager ALU.
        for (int i = 0; i < 6; i++) begin
            rdy = 1'b1;
            pulse(3'(i % 6), 4'(i), 4'(i + 1), 1);
            rdy = 1'b1;
            step();
        end
        rdy = 1'b0;
        step();
        chk("lit_wrap_count", int'(cnt_o), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) stb = ~stb;
            if (!stb) begin
                op = 3'($urandom_range(0, 7));
                a  = 4'($urandom);
                b  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            end
            rdy   = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 99) == 0);
            step();
        end
        flush = 1'b0; rdy = 1'b0; stb = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
